// File: rtl/note_request_tracker.sv
// Pending-note tracker: it collects voice requests, accepts one-hot grants from an
// external fixed-priority arbiter, and services each granted voice for SERVICE_CYCLES cycles.
module note_request_tracker #(
  parameter int n              = 8,
  parameter int SERVICE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  note_valid,
  input  logic [$clog2(n)-1:0]  note_index,
  input  logic [n-1:0]          grant,
  output logic [n-1:0]          request,
  output logic                  busy,
  output logic                  served_valid,
  output logic [$clog2(n)-1:0]  served_index,
  output logic [$clog2(n):0]    pending_count,
  output logic                  dup_error,
  output logic                  grant_error
);
  localparam int IW = $clog2(n);
  localparam int CW = IW + 1;
  localparam logic [7:0]   LOAD = 8'(SERVICE_CYCLES - 1);
  localparam logic [n-1:0] ONE  = n'(1);

  typedef enum logic {IDLE, SERVE} state_t;

  state_t          r_state, w_state_nxt;
  logic [7:0]      r_cnt, w_cnt_nxt;
  logic [n-1:0]    r_req, w_req_nxt, w_clr, w_set;
  logic [IW-1:0]   r_idx, w_gidx;
  logic            r_dup, r_gerr;
  logic            w_legal, w_accept, w_illegal, w_dup;
  logic [CW-1:0]   w_pop;

  // Legal grant: exactly one bit set, and that bit is currently requested.
  assign w_legal = (grant != '0) && ((grant & (grant - ONE)) == '0) && ((grant & r_req) == grant);

  always_comb begin
    w_gidx = '0;
    for (int i = 0; i < n; i++)
      if (grant[i]) w_gidx = IW'(i);
  end

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < n; i++)
      w_pop = w_pop + CW'(r_req[i]);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_illegal   = 1'b0;
    case (r_state)
      IDLE: begin
        if (grant != '0) begin
          if (w_legal) begin
            w_accept    = 1'b1;
            w_state_nxt = SERVE;
            w_cnt_nxt   = LOAD;
          end else begin
            w_illegal = 1'b1;
          end
        end
      end
      SERVE: begin
        if (r_cnt == 8'd0) w_state_nxt = IDLE;
        else               w_cnt_nxt   = r_cnt - 8'd1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // A new note on the bit being accepted this cycle wins over the clear.
  always_comb begin
    w_clr = w_accept ? grant : '0;
    w_set = '0;
    w_set[note_index] = note_valid;
    w_req_nxt = (r_req & ~w_clr) | w_set;
    w_dup = note_valid && r_req[note_index] && !w_clr[note_index];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= 8'd0;
      r_req   <= '0;
      r_idx   <= '0;
      r_dup   <= 1'b0;
      r_gerr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_req   <= w_req_nxt;
      if (w_accept)  r_idx  <= w_gidx;
      if (w_dup)     r_dup  <= 1'b1;
      if (w_illegal) r_gerr <= 1'b1;
    end
  end

  assign request       = r_req;
  assign busy          = (r_state == SERVE);
  assign served_valid  = (r_state == SERVE) && (r_cnt == 8'd0);
  assign served_index  = r_idx;
  assign pending_count = w_pop;
  assign dup_error     = r_dup;
  assign grant_error   = r_gerr;
endmodule

// File: tb/tb_note_request_tracker.sv
// Directed bench: two tracker instances (4-cycle and 1-cycle service), each fed by a
// lowest-bit-first arbiter model; instance A's grant can be forced for error cases.
module tb_note_request_tracker;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic       reset, nv, fen;
  logic [2:0] ni;
  logic [7:0] fval, grant, req;
  logic       busy, sv, dup, gerr;
  logic [2:0] sidx;
  logic [3:0] pend;

  logic       bnv;
  logic [2:0] bni;
  logic [7:0] bgrant, breq;
  logic       bbusy, bsv, bdup, bgerr;
  logic [2:0] bsidx;
  logic [3:0] bpend;

  function automatic logic [7:0] lowbit(input logic [7:0] r);
    return r & (~r + 8'd1);
  endfunction

  assign grant  = fen ? fval : lowbit(req);
  assign bgrant = lowbit(breq);

  note_request_tracker #(.n(8), .SERVICE_CYCLES(4)) dut_a (
    .clk(clk), .reset(reset), .note_valid(nv), .note_index(ni), .grant(grant),
    .request(req), .busy(busy), .served_valid(sv), .served_index(sidx),
    .pending_count(pend), .dup_error(dup), .grant_error(gerr));

  note_request_tracker #(.n(8), .SERVICE_CYCLES(1)) dut_b (
    .clk(clk), .reset(reset), .note_valid(bnv), .note_index(bni), .grant(bgrant),
    .request(breq), .busy(bbusy), .served_valid(bsv), .served_index(bsidx),
    .pending_count(bpend), .dup_error(bdup), .grant_error(bgerr));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered just after an acceptance edge on instance A; leaves it back in IDLE.
  task automatic svc(input logic [2:0] idx);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("svc%0d_busy%0d", idx, i), 32'(busy), 32'd1);
      chk($sformatf("svc%0d_sv%0d", idx, i), 32'(sv), (i == 3) ? 32'd1 : 32'd0);
      chk($sformatf("svc%0d_idx%0d", idx, i), 32'(sidx), 32'(idx));
      tick();
    end
    chk($sformatf("svc%0d_idle", idx), 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b1; nv = 1'b0; ni = '0; fen = 1'b0; fval = '0; bnv = 1'b0; bni = '0;
    tick(); tick();
    chk("rst_req",  32'(req),  32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sv",   32'(sv),   32'd0);
    chk("rst_pend", 32'(pend), 32'd0);
    chk("rst_idx",  32'(sidx), 32'd0);
    chk("rst_dup",  32'(dup),  32'd0);
    chk("rst_gerr", 32'(gerr), 32'd0);
    reset = 1'b0;

    // single note on voice 3
    nv = 1'b1; ni = 3'd3; tick(); nv = 1'b0;
    chk("one_req",  32'(req),  32'h08);
    chk("one_pend", 32'(pend), 32'd1);
    chk("one_busy", 32'(busy), 32'd0);
    tick();
    chk("one_clr", 32'(req), 32'd0);
    svc(3'd3);

    // priority drain of voices 7, 3, 0
    fen = 1'b1; fval = '0;
    nv = 1'b1; ni = 3'd7; tick(); ni = 3'd3; tick(); ni = 3'd0; tick(); nv = 1'b0;
    chk("drain_req",  32'(req),  32'h89);
    chk("drain_pend", 32'(pend), 32'd3);
    fen = 1'b0;
    tick(); chk("drain_p2", 32'(pend), 32'd2); svc(3'd0);
    tick(); chk("drain_p1", 32'(pend), 32'd1); svc(3'd3);
    tick(); chk("drain_p0", 32'(pend), 32'd0); svc(3'd7);

    // re-request in the acceptance cycle, then a true duplicate
    fen = 1'b1; fval = '0;
    nv = 1'b1; ni = 3'd0; tick();
    chk("rereq_req", 32'(req), 32'h01);
    fen = 1'b0; tick(); nv = 1'b0;
    chk("rereq_busy", 32'(busy), 32'd1);
    chk("rereq_keep", 32'(req),  32'h01);
    chk("rereq_dup",  32'(dup),  32'd0);
    nv = 1'b1; ni = 3'd0; tick(); nv = 1'b0;
    chk("dup_flag", 32'(dup), 32'd1);
    chk("dup_req",  32'(req), 32'h01);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("dup_rst", 32'(dup), 32'd0);
    chk("dup_rst_req", 32'(req), 32'd0);

    // illegal grants: multi-hot, then a single bit that is not requested
    fen = 1'b1; fval = '0;
    nv = 1'b1; ni = 3'd1; tick(); ni = 3'd2; tick(); nv = 1'b0;
    fval = 8'h06; tick();
    chk("ill2_busy", 32'(busy), 32'd0);
    chk("ill2_req",  32'(req),  32'h06);
    chk("ill2_gerr", 32'(gerr), 32'd1);
    chk("ill2_idx",  32'(sidx), 32'd0);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("ill_rst", 32'(gerr), 32'd0);
    fval = '0; nv = 1'b1; ni = 3'd1; tick(); nv = 1'b0;
    fval = 8'h10; tick();
    chk("illu_busy", 32'(busy), 32'd0);
    chk("illu_req",  32'(req),  32'h02);
    chk("illu_gerr", 32'(gerr), 32'd1);
    chk("illu_idx",  32'(sidx), 32'd0);

    // all voices pending: count saturates at n without wrapping
    reset = 1'b1; tick(); reset = 1'b0; fval = '0;
    for (int i = 0; i < 8; i++) begin
      nv = 1'b1; ni = 3'(i); tick();
    end
    nv = 1'b0;
    chk("full_req",  32'(req),  32'hff);
    chk("full_pend", 32'(pend), 32'd8);
    chk("full_dup",  32'(dup),  32'd0);

    // reset in the second service cycle
    reset = 1'b1; tick(); reset = 1'b0; fval = '0;
    nv = 1'b1; ni = 3'd7; tick(); ni = 3'd0; tick(); nv = 1'b0;
    chk("mid_req", 32'(req), 32'h81);
    fen = 1'b0; nv = 1'b1; ni = 3'd0; tick(); nv = 1'b0;
    chk("mid_busy1", 32'(busy), 32'd1);
    chk("mid_req1",  32'(req),  32'h81);
    tick();
    chk("mid_busy2", 32'(busy), 32'd1);
    chk("mid_sv2",   32'(sv),   32'd0);
    reset = 1'b1; tick();
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_req0", 32'(req),  32'd0);
    chk("mid_pend", 32'(pend), 32'd0);
    chk("mid_sv",   32'(sv),   32'd0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("mid_after_sv%0d", i), 32'(sv), 32'd0);
    end

    // one-cycle service on instance B
    bnv = 1'b1; bni = 3'd5; tick(); bni = 3'd2; tick(); bnv = 1'b0;
    chk("b1_busy", 32'(bbusy), 32'd1);
    chk("b1_sv",   32'(bsv),   32'd1);
    chk("b1_idx",  32'(bsidx), 32'd5);
    chk("b1_req",  32'(breq),  32'h04);
    tick();
    chk("b1_busy_off", 32'(bbusy), 32'd0);
    chk("b1_sv_off",   32'(bsv),   32'd0);
    tick();
    chk("b2_busy", 32'(bbusy), 32'd1);
    chk("b2_sv",   32'(bsv),   32'd1);
    chk("b2_idx",  32'(bsidx), 32'd2);
    chk("b2_req",  32'(breq),  32'd0);
    tick();
    chk("b2_busy_off", 32'(bbusy), 32'd0);
    chk("b2_sv_off",   32'(bsv),   32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
